// File: rtl/risc_pkg.sv
// Shared types and constants for the fetch front end.
package risc_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RISC_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: redirect target, sequential advance or hold, plus misalign detect.
module pc_next_sel
  import risc_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            taken_i,
  input  logic            advance_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            misalign_o
);

  always_comb begin
    pc_next_o = pc_i;
    if (taken_i) begin
      // Low bits of the target are dropped so fetches stay word aligned.
      pc_next_o = {target_i[XLEN-1:2], 2'b00};
    end else if (advance_i) begin
      pc_next_o = pc_i + 32'd4;
    end
  end

  assign misalign_o = taken_i & (target_i[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC plus a single-outstanding instruction fetch with a decode handshake.
module pc_fetch_unit
  import risc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = RISC_NOP
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            branch_i,
  input  logic            zero_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            stall_i,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_resp_valid_i,
  input  logic [XLEN-1:0] imem_resp_data_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_out_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            decode_ready_i,
  output logic            misalign_err_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            squash_q, squash_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] instr_out_q, instr_out_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            misalign_q, misalign_d;

  logic taken;
  logic handshake;
  logic advance;

  assign taken     = branch_i & zero_i;
  assign handshake = (state_q == ST_REQ) & imem_req_ready_i;

  pc_next_sel u_pc_next_sel (
    .pc_i      (pc_q),
    .target_i  (branch_target_i),
    .taken_i   (taken),
    .advance_i (advance),
    .pc_next_o (pc_d),
    .misalign_o(misalign_d)
  );

  always_comb begin
    state_d       = state_q;
    squash_d      = squash_q;
    instr_valid_d = instr_valid_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    advance       = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (handshake) begin
          state_d  = ST_WAIT;
          squash_d = taken;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid_i) begin
          if (squash_q || taken) begin
            squash_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            advance       = 1'b1;
            instr_out_d   = imem_resp_data_i;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            state_d       = ST_HOLD;
          end
        end else if (taken) begin
          squash_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (taken || (decode_ready_i && !stall_i)) begin
          instr_valid_d = 1'b0;
          instr_out_d   = NOP_INSTR;
          state_d       = ST_REQ;
        end
      end
      default: begin
        state_d  = ST_REQ;
        squash_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      squash_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_out_q   <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      squash_q      <= squash_d;
      instr_valid_q <= instr_valid_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      misalign_q    <= misalign_d;
    end
  end

  // Request is masked while reset is held so it drops immediately, then rises right after release.
  assign imem_req_valid_o = (state_q == ST_REQ) & ~reset_i;
  assign imem_req_addr_o  = pc_q;
  assign instr_valid_o    = instr_valid_q;
  assign instr_out_o      = instr_out_q;
  assign instr_pc_o       = instr_pc_q;
  assign misalign_err_o   = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed checks of the fetch unit: reset, handshake, stall, squash, redirect, misalign, wrap.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        branch_i, zero_i, stall_i;
  logic [31:0] branch_target_i;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_out_o;
  logic [31:0] instr_pc_o;
  logic        decode_ready_i;
  logic        misalign_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clock_i = ~clock_i;

  pc_fetch_unit dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .branch_i         (branch_i),
    .zero_i           (zero_i),
    .branch_target_i  (branch_target_i),
    .stall_i          (stall_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_resp_valid_i(imem_resp_valid_i),
    .imem_resp_data_i (imem_resp_data_i),
    .instr_valid_o    (instr_valid_o),
    .instr_out_o      (instr_out_o),
    .instr_pc_o       (instr_pc_o),
    .decode_ready_i   (decode_ready_i),
    .misalign_err_o   (misalign_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // Issues the pending request and returns a 1-cycle response; leaves the DUT in HOLD.
  task automatic fetch(input logic [31:0] data);
    tick();
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = data;
    tick();
    imem_resp_valid_i = 1'b0;
  endtask

  task automatic consume();
    decode_ready_i = 1'b1;
    tick();
    decode_ready_i = 1'b0;
  endtask

  task automatic take(input logic [31:0] tgt);
    branch_i        = 1'b1;
    zero_i          = 1'b1;
    branch_target_i = tgt;
  endtask

  task automatic untake();
    branch_i = 1'b0;
    zero_i   = 1'b0;
  endtask

  initial begin
    reset_i           = 1'b1;
    branch_i          = 1'b0;
    zero_i            = 1'b0;
    stall_i           = 1'b0;
    branch_target_i   = '0;
    imem_req_ready_i  = 1'b1;
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i  = '0;
    decode_ready_i    = 1'b0;

    #3;
    chk("rst_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    chk("rst_req_addr", imem_req_addr_o, 32'h0);
    chk("rst_instr_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr_out", instr_out_o, NOP);
    chk("rst_instr_pc", instr_pc_o, 32'h0);
    chk("rst_misalign", {31'd0, misalign_err_o}, 32'd0);

    tick();
    reset_i = 1'b0;
    #1;
    chk("first_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
    chk("first_req_addr", imem_req_addr_o, 32'h0);

    tick();
    chk("wait_no_req", {31'd0, imem_req_valid_o}, 32'd0);
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'h0050_0093;
    tick();
    imem_resp_valid_i = 1'b0;
    chk("f0_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("f0_instr", instr_out_o, 32'h0050_0093);
    chk("f0_pc", instr_pc_o, 32'h0);

    stall_i        = 1'b1;
    decode_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", instr_out_o, 32'h0050_0093);
      chk("stall_pc", instr_pc_o, 32'h0);
      chk("stall_no_req", {31'd0, imem_req_valid_o}, 32'd0);
    end
    stall_i = 1'b0;
    tick();
    decode_ready_i = 1'b0;
    chk("post_stall_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("post_stall_req", {31'd0, imem_req_valid_o}, 32'd1);
    chk("post_stall_addr", imem_req_addr_o, 32'h4);

    fetch(32'h1111_1111);
    chk("f4_pc", instr_pc_o, 32'h4);
    consume();
    chk("req8_addr", imem_req_addr_o, 32'h8);

    // Branch while the fetch at 8 is outstanding; its late response must be dropped.
    tick();
    take(32'h40);
    tick();
    untake();
    chk("sq_no_req", {31'd0, imem_req_valid_o}, 32'd0);
    tick();
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid_i = 1'b0;
    chk("sq_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("sq_req", {31'd0, imem_req_valid_o}, 32'd1);
    chk("sq_addr", imem_req_addr_o, 32'h40);

    imem_req_ready_i = 1'b0;
    take(32'h10);
    tick();
    untake();
    imem_req_ready_i = 1'b1;
    chk("req_redirect_addr", imem_req_addr_o, 32'h10);
    fetch(32'h2222_2222);
    chk("f10_pc", instr_pc_o, 32'h10);
    chk("f10_valid", {31'd0, instr_valid_o}, 32'd1);
    take(32'h100);
    tick();
    untake();
    chk("hold_br_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("hold_br_nop", instr_out_o, NOP);
    chk("hold_br_addr", imem_req_addr_o, 32'h100);

    imem_req_ready_i = 1'b0;
    take(32'h102);
    tick();
    untake();
    chk("mis_pulse", {31'd0, misalign_err_o}, 32'd1);
    chk("mis_addr", imem_req_addr_o, 32'h100);
    tick();
    chk("mis_clear", {31'd0, misalign_err_o}, 32'd0);

    take(32'hFFFF_FFFC);
    tick();
    untake();
    imem_req_ready_i = 1'b1;
    chk("top_addr", imem_req_addr_o, 32'hFFFF_FFFC);
    fetch(32'h3333_3333);
    chk("top_pc", instr_pc_o, 32'hFFFF_FFFC);
    consume();
    chk("wrap_addr", imem_req_addr_o, 32'h0);

    // Redirect in the same cycle as the handshake squashes that fetch.
    take(32'h200);
    tick();
    untake();
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'h4444_4444;
    tick();
    imem_resp_valid_i = 1'b0;
    chk("hs_br_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("hs_br_addr", imem_req_addr_o, 32'h200);

    tick();
    #2;
    reset_i = 1'b1;
    #1;
    chk("async_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    chk("async_addr", imem_req_addr_o, 32'h0);
    chk("async_instr_pc", instr_pc_o, 32'h0);
    chk("async_instr_out", instr_out_o, NOP);
    tick();
    reset_i = 1'b0;
    #1;
    chk("restart_req", {31'd0, imem_req_valid_o}, 32'd1);
    chk("restart_addr", imem_req_addr_o, 32'h0);
    fetch(32'h5555_5555);
    chk("restart_instr", instr_out_o, 32'h5555_5555);
    chk("restart_pc", instr_pc_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer of the branch/zero next-PC decision. Holds the architectural PC and turns that decision into instruction-memory fetches.
- Each fetched instruction is presented to decode with a valid/ready handshake.
- Sits between the branch-resolution logic (ALU zero flag plus the controller branch signal) and the instruction memory / decode stage.
- One outstanding fetch at a time. Taken branches redirect the PC and squash in-flight or held instructions.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, value driven on instr_out when no valid instruction is held (addi x0,x0,0).

Ports:
- clock  input  1  single system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- branch  input  1  controller branch signal.
- zero  input  1  ALU zero flag.
- branch_target  input  32  PC + shifted immediate from the branch adder.
- stall  input  1  pipeline hold from the hazard unit.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  fetch address, word aligned.
- imem_req_ready  input  1  instruction memory accepts the request.
- imem_resp_valid  input  1  response valid; arrives 1 or more cycles after acceptance.
- imem_resp_data  input  32  fetched instruction.
- instr_valid  output  1  instr_out/instr_pc are valid for decode.
- instr_out  output  32  instruction to decode.
- instr_pc  output  32  address of instr_out.
- decode_ready  input  1  decode consumes the instruction this cycle.
- misalign_err  output  1  one-cycle pulse when a taken branch has target[1:0] != 0.

Behaviour:
- Reset (asynchronous, active-high, clears immediately):
  - pc = RESET_PC, state = REQ, squash = 0.
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - instr_valid = 0, instr_out = NOP_INSTR, instr_pc = RESET_PC, misalign_err = 0.
  - First request is issued in the first clock cycle after reset deasserts.
- taken = branch & zero, sampled each posedge.
- Redirect rules (apply when taken = 1):
  - Redirect has priority over stall and over normal advance.
  - pc <= {branch_target[31:2], 2'b00}.
  - misalign_err pulses for one cycle if branch_target[1:0] != 0; the redirect still occurs.
- FSM states REQ, WAIT, HOLD:
  - REQ: imem_req_valid = 1, imem_req_addr = pc.
    - Handshake when req_valid & req_ready: go to WAIT.
    - Taken with no handshake: address switches to the new pc next cycle; stay in REQ.
    - Taken in the same cycle as a handshake: go to WAIT with squash = 1.
  - WAIT: imem_req_valid = 0.
    - Taken: squash <= 1; pc redirects.
    - On imem_resp_valid with squash (or taken in the same cycle): discard data, clear squash, go to REQ.
    - On imem_resp_valid otherwise: instr_out <= data, instr_pc <= pc, pc <= pc + 4, instr_valid <= 1, go to HOLD.
  - HOLD: instr_valid = 1; instr_out and instr_pc are stable.
    - Taken: instr_valid <= 0, instr_out <= NOP_INSTR, go to REQ at the redirected pc.
    - decode_ready & !stall: instr_valid <= 0, go to REQ.
    - Otherwise hold; stall never blocks a response in WAIT.
- Latency:
  - Handshake to instr_valid = response latency + 1 cycle.
  - Consume to next request: 1 cycle.
  - Redirect to request at the target: 1 cycle when no fetch is outstanding.
- Arithmetic: PC + 4 is a 32-bit modulo add; 32'hFFFFFFFC wraps to 32'h00000000 with no flag.
- imem_req_addr[1:0] is always 2'b00.
- A response arriving while state != WAIT is a protocol error; it is ignored.

Decomposition:
- Shared package (risc_pkg) holds:
  - FSM state encoding (REQ = 2'd0, WAIT = 2'd1, HOLD = 2'd2).
  - NOP_INSTR constant and XLEN = 32.
- One natural sub-module, pc_next_sel: combinational selection among pc + 4, aligned target and hold, plus misalign detection. The FSM and registers stay in pc_fetch_unit.

Test Plan:
- Reset release, then memory ready and 1-cycle response returning 32'h00500093 → req at addr 0 in cycle 1; instr_valid=1, instr_out=32'h00500093, instr_pc=0; next req addr=4 after decode_ready.
- stall=1 for 3 cycles while in HOLD → instr_out/instr_pc unchanged and no new request; after stall drops with decode_ready=1, one cycle later req addr = instr_pc + 4.
- branch=1, zero=1, branch_target=32'h40 while a fetch at 8 is outstanding; response 32'hDEADBEEF arrives 2 cycles later → response discarded, instr_valid stays 0, next req addr=32'h40.
- Taken branch during HOLD holding pc 0x10, target 0x100 → instr_valid drops next cycle, instr_out=NOP_INSTR, next req addr=32'h100.
- branch_target=32'h102 taken → misalign_err=1 for exactly one cycle; req addr=32'h100.
- pc=32'hFFFFFFFC fetched → next req addr=32'h00000000. Asserting reset mid-WAIT → outputs return to reset values immediately (asynchronously); restart fetch at RESET_PC.
